// File: rtl/tile_frame_streamer_if.sv
// Byte stream from tile_frame_streamer to the OLED SPI serializer.
// The serializer takes one byte per cycle with a valid/ready handshake and a command/data flag.
interface tile_frame_streamer_if;
    logic [7:0] out_byte;
    logic       out_dc;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_byte, out_dc, out_valid, input out_ready);
    modport slave  (input out_byte, out_dc, out_valid, output out_ready);
endinterface

// File: rtl/tile_frame_streamer.sv
// Emits the address-window commands, then one framebuffer rendered from a snapshot of the tile map.
// Optional macro TILE_GAP_EN blanks the first and last column of every lane.
module tile_frame_streamer #(
    parameter int NUM_LANES = 4,
    parameter int NUM_ROWS  = 4,
    parameter int WIDTH     = 128,
    parameter int PAGES     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_done,
    input  logic                          frame_start,
    input  logic [NUM_LANES*NUM_ROWS-1:0] tile_map,
    output logic                          busy,
    output logic                          frame_done,
    tile_frame_streamer_if.master         bs
);
    localparam int TW     = NUM_LANES * NUM_ROWS;
    localparam int LANE_W = WIDTH / NUM_LANES;
    localparam int ROW_H  = PAGES / NUM_ROWS;
    localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t          state, state_n;
    logic [2:0]      cmd_idx, cmd_idx_n;
    logic [CW-1:0]   col, col_n;
    logic [PW-1:0]   page, page_n;
    logic [TW-1:0]   snap, snap_n;
    logic [7:0]      byte_q, byte_n;
    logic            dc_q, dc_n;
    logic            valid_q, valid_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            xfer;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return 8'h00;
            3'd2:    return 8'(WIDTH - 1);
            3'd3:    return 8'h22;
            3'd4:    return 8'h00;
            default: return 8'(PAGES - 1);
        endcase
    endfunction

    function automatic logic [7:0] pix(input logic [CW-1:0] c, input logic [PW-1:0] p,
                                       input logic [TW-1:0] m);
        int            lane, row;
        logic [TW-1:0] sh;
        logic          hit;
        lane = int'(c) / LANE_W;
        row  = int'(p) / ROW_H;
        sh   = m >> (row * NUM_LANES + lane);
        hit  = sh[0];
`ifdef TILE_GAP_EN
        begin
            int lc;
            lc = int'(c) % LANE_W;
            if (lc == 0 || lc == LANE_W - 1) hit = 1'b0;
        end
`else
`endif
        return hit ? 8'hFF : 8'h00;
    endfunction

    assign xfer = valid_q && bs.out_ready;

    always_comb begin
        state_n   = state;
        cmd_idx_n = cmd_idx;
        col_n     = col;
        page_n    = page;
        snap_n    = snap;
        byte_n    = byte_q;
        dc_n      = dc_q;
        valid_n   = valid_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        unique case (state)
            IDLE: if (frame_start && init_done) begin
                snap_n    = tile_map;
                busy_n    = 1'b1;
                cmd_idx_n = 3'd0;
                byte_n    = cmd_byte(3'd0);
                dc_n      = 1'b0;
                valid_n   = 1'b1;
                state_n   = CMD;
            end
            CMD: if (xfer) begin
                if (cmd_idx == 3'd5) begin
                    col_n   = '0;
                    page_n  = '0;
                    byte_n  = pix('0, '0, snap);
                    dc_n    = 1'b1;
                    state_n = DATA;
                end else begin
                    cmd_idx_n = cmd_idx + 3'd1;
                    byte_n    = cmd_byte(cmd_idx + 3'd1);
                end
            end
            DATA: if (xfer) begin
                // Next byte comes from the post-increment position so the stream never stalls.
                if (col == CW'(WIDTH - 1)) begin
                    col_n = '0;
                    if (page == PW'(PAGES - 1)) begin
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        page_n = page + PW'(1);
                    end
                end else begin
                    col_n = col + CW'(1);
                end
                if (state_n == DONE) begin
                    byte_n = 8'h00;
                    dc_n   = 1'b0;
                end else begin
                    byte_n = pix(col_n, page_n, snap);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cmd_idx <= '0;
            col     <= '0;
            page    <= '0;
            snap    <= '0;
            byte_q  <= 8'h00;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cmd_idx <= cmd_idx_n;
            col     <= col_n;
            page    <= page_n;
            snap    <= snap_n;
            byte_q  <= byte_n;
            dc_q    <= dc_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bs.out_byte  = byte_q;
    assign bs.out_dc    = dc_q;
    assign bs.out_valid = valid_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
endmodule

// File: tb/tb_tile_frame_streamer.sv
// Directed bench for tile_frame_streamer: expected bytes are queued per frame and popped on each transfer.
module tb_tile_frame_streamer;
    localparam int TOTAL = 6 + 128 * 8;
`ifdef TILE_GAP_EN
    localparam int FF_ONE = 60;
    localparam int FF_ALL = 960;
`else
    localparam int FF_ONE = 64;
    localparam int FF_ALL = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        frame_start;
    logic [15:0] tile_map;
    logic        busy;
    logic        frame_done;
    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  sb[$];
    int          ff_cnt;

    tile_frame_streamer_if bs ();

    tile_frame_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .frame_start(frame_start),
        .tile_map   (tile_map),
        .busy       (busy),
        .frame_done (frame_done),
        .bs         (bs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: six window commands, then page-major / column-minor pixels.
    task automatic push_frame(input logic [15:0] map);
        logic [15:0] sh;
        logic        on;
        sb.push_back({1'b0, 8'h21});
        sb.push_back({1'b0, 8'h00});
        sb.push_back({1'b0, 8'h7F});
        sb.push_back({1'b0, 8'h22});
        sb.push_back({1'b0, 8'h00});
        sb.push_back({1'b0, 8'h07});
        for (int p = 0; p < 8; p++)
            for (int c = 0; c < 128; c++) begin
                sh = map >> ((p / 2) * 4 + c / 32);
                on = sh[0];
`ifdef TILE_GAP_EN
                if (c % 32 == 0 || c % 32 == 31) on = 1'b0;
`endif
                sb.push_back({1'b1, on ? 8'hFF : 8'h00});
            end
    endtask

    task automatic run_frame(input logic [15:0] map, input bit rnd, input bit mid_start,
                             input int chg_at, input int rst_at);
        int         count = 0;
        int         cyc   = 0;
        bit         held  = 0;
        bit         fired = 0;
        bit         aborted = 0;
        logic [8:0] hv;
        logic [8:0] exp;
        ff_cnt = 0;
        @(negedge clk);
        tile_map    = map;
        init_done   = 1'b1;
        frame_start = 1'b1;
        out_ready_drive(1'b1);
        push_frame(map);
        @(posedge clk); #1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_after_start", 32'(bs.out_valid), 32'd1);
        while (count < TOTAL && cyc < 20000 && !aborted) begin
            @(negedge clk);
            cyc++;
            frame_start = 1'b0;
            if (held)
                check("hold_stable", 32'({bs.out_valid, bs.out_dc, bs.out_byte}), 32'({1'b1, hv}));
            if (mid_start && !fired && count == 100) begin
                frame_start = 1'b1;
                fired = 1;
            end
            if (rnd && count == 50) init_done = 1'b0;
            if (chg_at >= 0 && count >= chg_at) tile_map = 16'h0000;
            if (rst_at >= 0 && count == rst_at) begin
                aborted = 1;
            end else begin
                out_ready_drive(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                check("busy_during", 32'(busy), 32'd1);
                if (bs.out_valid && bs.out_ready) begin
                    if (sb.size() == 0) begin
                        check("extra_byte", 32'(count), 32'(TOTAL));
                    end else begin
                        exp = sb.pop_front();
                        check($sformatf("byte%0d", count), 32'({bs.out_dc, bs.out_byte}), 32'(exp));
                    end
                    if (bs.out_dc && bs.out_byte == 8'hFF) ff_cnt++;
                    count++;
                    held = 0;
                end else if (bs.out_valid) begin
                    held = 1;
                    hv   = {bs.out_dc, bs.out_byte};
                end else begin
                    held = 0;
                end
            end
        end
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check("rst_valid", 32'(bs.out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(frame_done), 32'd0);
            check("rst_byte", 32'(bs.out_byte), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
            repeat (5) begin
                @(negedge clk);
                check("post_rst_quiet", 32'({frame_done, bs.out_valid, busy}), 32'd0);
            end
        end else begin
            check("frame_timeout", 32'(count), 32'(TOTAL));
            @(posedge clk); #1;
            check("done_pulse", 32'(frame_done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            check("done_valid", 32'(bs.out_valid), 32'd0);
            @(posedge clk); #1;
            check("done_one_cycle", 32'(frame_done), 32'd0);
            check("sb_empty", 32'(sb.size()), 32'd0);
        end
        frame_start = 1'b0;
        init_done   = 1'b1;
    endtask

    task automatic out_ready_drive(input logic r);
        bs.out_ready = r;
    endtask

    initial begin
        rst         = 1'b1;
        init_done   = 1'b0;
        frame_start = 1'b0;
        tile_map    = 16'h0000;
        bs.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_valid", 32'(bs.out_valid), 32'd0);
        check("reset_byte", 32'(bs.out_byte), 32'd0);
        check("reset_dc", 32'(bs.out_dc), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // frame_start without init_done must be ignored
        frame_start = 1'b1;
        tile_map    = 16'hFFFF;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("no_init_quiet", 32'({bs.out_valid, busy}), 32'd0);
        end

        run_frame(16'h0001, 1'b0, 1'b0, -1, -1);
        check("ff_count_one", 32'(ff_cnt), 32'(FF_ONE));

        run_frame(16'hA5C3, 1'b1, 1'b0, -1, -1);

        run_frame(16'h0001, 1'b1, 1'b1, -1, -1);
        check("ff_count_one_rnd", 32'(ff_cnt), 32'(FF_ONE));

        run_frame(16'hFFFF, 1'b0, 1'b0, 300, -1);
        check("ff_count_snapshot", 32'(ff_cnt), 32'(FF_ALL));

        run_frame(16'h5A5A, 1'b0, 1'b0, -1, 506);

        run_frame(16'h0001, 1'b0, 1'b0, -1, -1);
        check("ff_count_restart", 32'(ff_cnt), 32'(FF_ONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tile_frame_streamer.md
Name: tile_frame_streamer

Overview:
Upstream byte source for the OLED SPI serializer. After display init completes, on each frame request it emits the column/page address window commands, then streams one full framebuffer (WIDTH x PAGES bytes) rendered from a lane/row tile occupancy map. Output is a byte stream with a command/data flag and a valid/ready handshake, consumed byte-per-byte by the serializer.

Parameters:
NUM_LANES, 4, vertical tile lanes across the screen; WIDTH must be divisible by NUM_LANES.
NUM_ROWS, 4, tile rows down the screen; PAGES must be divisible by NUM_ROWS.
WIDTH, 128, display columns.
PAGES, 8, display pages (8 pixel rows each).

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
init_done  in  1  serializer has finished its init sequence; level
frame_start  in  1  single-cycle frame request
tile_map  in  NUM_LANES*NUM_ROWS  bit [row*NUM_LANES+lane] = tile present
busy  out  1  high from the accepted frame_start through the last data byte transfer
frame_done  out  1  one-cycle pulse after the last data byte transfers
out_byte  out  8  byte to serializer
out_dc  out  1  0 = command byte, 1 = data byte
out_valid  out  1  out_byte/out_dc valid
out_ready  in  1  serializer accepts byte this cycle

Behaviour:
- Reset (rst high at posedge): state IDLE; busy=0, frame_done=0, out_valid=0, out_byte=8'h00, out_dc=0; all counters cleared. Reset mid-frame aborts the frame immediately; no frame_done pulse.
- Transfer occurs on any posedge with out_valid && out_ready. While out_valid && !out_ready, out_byte and out_dc are held stable. out_valid never drops without a transfer, except on reset.
- States: IDLE, CMD, DATA, DONE.
- IDLE: frame_start && init_done at edge N -> latch tile_map into an internal snapshot, busy=1, enter CMD. At N+1, out_valid=1 with the first command byte. frame_start without init_done is ignored.
- CMD: six command bytes in order, out_dc=0: 8'h21, 8'h00, WIDTH-1, 8'h22, 8'h00, PAGES-1. A 3-bit index advances on each transfer. The transfer of the 6th byte enters DATA.
- DATA: WIDTH*PAGES bytes, out_dc=1, in order page 0..PAGES-1. Within each page, column 0..WIDTH-1. Column and page counters advance on transfer only. Column wraps WIDTH-1 -> 0 and increments page. The transfer at page PAGES-1 / column WIDTH-1 enters DONE.
- Pixel rule: lane = col / (WIDTH/NUM_LANES); row = page / (PAGES/NUM_ROWS). byte = 8'hFF if snapshot[row*NUM_LANES+lane] is set, else 8'h00 (gap rule below).
- out_byte is registered. The next byte is computed from the post-increment counters so it is ready in the cycle after a transfer. Back-to-back transfers are sustained with out_ready held high: 1 byte/cycle.
- DONE: frame_done=1 and busy=0 for exactly one cycle, out_valid=0, then IDLE.
- frame_start while busy or in DONE is ignored; there is no queuing. tile_map changes during a frame do not affect it, because the snapshot is used.
- init_done falling mid-frame is ignored; the frame completes.

Optional Feature:
TILE_GAP_EN
- Defined: the first and last column of every lane render 8'h00 even when the tile is present, giving visible 1-px gaps between lanes.
- Undefined: the tile fills the full lane width.
- Command sequence and byte count are identical in both cases.

Test Plan:
- Reset then init_done=1, frame_start pulse, out_ready=1 constantly -> busy the next cycle. Bytes 21,00,7F,22,00,07 with dc=0, then 1024 dc=1 bytes. frame_done pulses exactly one cycle after the 1030th transfer.
- tile_map=16'h0001 (row 0, lane 0), no gap -> bytes for page 0-1, col 0-31 = FF; all others 00. With TILE_GAP_EN -> cols 0 and 31 of those pages = 00.
- out_ready toggled pseudo-randomly -> out_byte/out_dc stable whenever valid && !ready. Byte sequence is identical to the out_ready=1 run.
- frame_start with init_done=0 -> no output, busy stays 0. frame_start mid-frame -> ignored, still exactly 1030 bytes.
- tile_map=16'hFFFF latched, then changed to 16'h0000 mid-DATA -> all 1024 data bytes = FF.
- rst asserted at data byte 500 -> next cycle out_valid=0, busy=0, no frame_done. A new frame_start restarts from command 21.
